// File: rtl/feature_map_serializer_pkg.sv
// Shared definitions for the packed-feature sink: FSM states, channel-index width
// and the channel-slice ordering every packed-feature block agrees on.
package feature_map_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Channel 0 occupies the least significant slice of a packed feature word.
    localparam bit CH0_AT_LSB = 1'b1;

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int ch_base(input int ch, input int channels, input int data_w);
        return CH0_AT_LSB ? ch * data_w : (channels - 1 - ch) * data_w;
    endfunction

endpackage

// File: rtl/feature_map_serializer_if.sv
// Packed-feature input plus serialized channel stream. The serializer uses the
// slave modport; the producer/consumer environment uses master.
interface feature_map_serializer_if
    import feature_map_serializer_pkg::*;
#(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 8
);
    localparam int CH_W = ch_w(CHANNELS);

    logic [DATA_WIDHT*CHANNELS-1:0] Data_In;
    logic                           Valid_In;
    logic [DATA_WIDHT-1:0]          Data_Out;
    logic                           Valid_Out;
    logic                           Ready_In;
    logic [CH_W-1:0]                Ch_Idx;
    logic                           Last_Row;
    logic                           Last_Frame;
    logic                           Frame_Done;
    logic                           Overflow;

    modport master (
        output Data_In, Valid_In, Ready_In,
        input  Data_Out, Valid_Out, Ch_Idx, Last_Row, Last_Frame, Frame_Done, Overflow
    );

    modport slave (
        input  Data_In, Valid_In, Ready_In,
        output Data_Out, Valid_Out, Ch_Idx, Last_Row, Last_Frame, Frame_Done, Overflow
    );

endinterface

// File: rtl/feature_map_serializer_sync_fifo.sv
// Plain synchronous FIFO; dout shows the head entry combinationally so a pop
// can load it into a register in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit separates full from empty when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/feature_map_serializer.sv
// Buffers channel-packed pixel words and replays them one channel per beat on a
// valid/ready stream, tagging row and frame ends from column/row counters.
module feature_map_serializer
    import feature_map_serializer_pkg::*;
#(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 8,
    parameter int MAP_WIDTH  = 44,
    parameter int MAP_HEIGHT = 44,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    feature_map_serializer_if.slave bus
);
    localparam int CH_W   = ch_w(CHANNELS);
    localparam int WORD_W = DATA_WIDHT * CHANNELS;
    localparam int COL_W  = (MAP_WIDTH  > 1) ? $clog2(MAP_WIDTH)  : 1;
    localparam int ROW_W  = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAP_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAP_HEIGHT - 1);

    state_t                              state;
    state_t                              state_nxt;
    logic [WORD_W-1:0]                   word_q;
    logic [WORD_W-1:0]                   fifo_dout;
    logic [CHANNELS-1:0][DATA_WIDHT-1:0] lanes;
    logic [CH_W-1:0]                     ch_q;
    logic [COL_W-1:0]                    col_q;
    logic [ROW_W-1:0]                    row_q;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                push;
    logic                                pop;
    logic                                accept;
    logic                                last_ch;
    logic                                pix_done;
    logic                                at_last_col;
    logic                                at_last_row;
    logic                                overflow_q;
    logic                                frame_done_q;

    assign accept      = (state == SEND) && bus.Ready_In;
    assign last_ch     = (ch_q == LAST_CH);
    assign pix_done    = accept && last_ch;
    assign at_last_col = (col_q == LAST_COL);
    assign at_last_row = (row_q == LAST_ROW);

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push = bus.Valid_In && (!fifo_full || pop);

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.Data_In),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (pix_done) begin
                    if (!fifo_empty) pop       = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            word_q       <= '0;
            ch_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_done_q <= pix_done && at_last_col && at_last_row;

            if (bus.Valid_In && fifo_full && !pop) overflow_q <= 1'b1;

            if (pop) word_q <= fifo_dout;

            if (pop)         ch_q <= '0;
            else if (accept) ch_q <= last_ch ? '0 : ch_q + 1'b1;

            if (pix_done) begin
                if (at_last_col) begin
                    col_q <= '0;
                    row_q <= at_last_row ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        assign lanes[k] = word_q[ch_base(k, CHANNELS, DATA_WIDHT) +: DATA_WIDHT];
    end

    assign bus.Data_Out   = lanes[ch_q];
    assign bus.Valid_Out  = (state == SEND);
    assign bus.Ch_Idx     = ch_q;
    assign bus.Last_Row   = (state == SEND) && last_ch && at_last_col;
    assign bus.Last_Frame = bus.Last_Row && at_last_row;
    assign bus.Frame_Done = frame_done_q;
    assign bus.Overflow   = overflow_q;

endmodule
